// File: rtl/order_manager.sv
// order_manager: turns accepted trading decisions into single-lot orders, enforcing a net
// position limit, post-order cooldown and a latched kill halt. Define ORDER_MGR_FLATTEN_EN to flatten on kill.
module order_manager #(
  parameter logic signed [31:0] BUY_THRESH   = 32'sh0000_8000,
  parameter logic signed [31:0] SELL_THRESH  = 32'shFFFF_8000,
  parameter logic signed [31:0] LOT_SIZE     = 32'sh0001_0000,
  parameter logic signed [31:0] POS_LIMIT    = 32'sh000A_0000,
  parameter int                 COOLDOWN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] signal_in,
  input  logic        allow_trade,
  input  logic        kill_switch,
  output logic        ord_valid,
  input  logic        ord_ready,
  output logic        ord_side,
  output logic [31:0] ord_qty,
  output logic [15:0] ord_id,
  output logic [31:0] position_out,
  output logic        halted,
  input  logic        halt_clear
);

  localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic signed [32:0] LIM_P   = 33'(POS_LIMIT);
  localparam logic signed [32:0] LIM_N   = -LIM_P;
  localparam logic signed [32:0] LOT_EXT = 33'(LOT_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    ISSUE,
    COOLDOWN,
`ifdef ORDER_MGR_FLATTEN_EN
    FLATTEN,
`endif
    HALT
  } state_t;

  state_t             state, state_d;
  logic signed [31:0] sig_q, pos_q, qty_q;
  logic               allow_q, kill_q, side_q;
  logic [15:0]        id_q;
  logic [CW-1:0]      cnt_q;
  logic signed [32:0] pos_plus, pos_minus;
  logic               buy_ok, sell_ok;

  // Position +/- one lot at 33 bits so limit checks can never wrap
  assign pos_plus  = 33'(pos_q) + LOT_EXT;
  assign pos_minus = 33'(pos_q) - LOT_EXT;
  assign buy_ok    = (sig_q >= BUY_THRESH)  && (pos_plus  <= LIM_P);
  assign sell_ok   = (sig_q <= SELL_THRESH) && (pos_minus >= LIM_N);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (in_valid) state_d = DECIDE;
      DECIDE: begin
        if (kill_q) begin
`ifdef ORDER_MGR_FLATTEN_EN
          state_d = (pos_q != '0) ? FLATTEN : HALT;
`else
          state_d = HALT;
`endif
        end else if (allow_q && (buy_ok || sell_ok)) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:    if (ord_ready) state_d = (COOLDOWN_CYC > 0) ? COOLDOWN : IDLE;
      COOLDOWN: if (cnt_q == '0) state_d = IDLE;
`ifdef ORDER_MGR_FLATTEN_EN
      FLATTEN:  if (ord_ready) state_d = HALT;
`endif
      HALT:     if (halt_clear) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sig_q   <= '0;
      allow_q <= 1'b0;
      kill_q  <= 1'b0;
      side_q  <= 1'b0;
      qty_q   <= '0;
      id_q    <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sig_q   <= signed'(signal_in);
            allow_q <= allow_trade;
            kill_q  <= kill_switch;
          end
        end
        DECIDE: begin
          side_q <= buy_ok;
          qty_q  <= LOT_SIZE;
`ifdef ORDER_MGR_FLATTEN_EN
          // Flatten order closes the whole position in one transfer
          if (kill_q) begin
            side_q <= pos_q[31];
            qty_q  <= pos_q[31] ? -pos_q : pos_q;
          end
`endif
        end
        ISSUE: begin
          if (ord_ready) begin
            pos_q <= side_q ? (pos_q + LOT_SIZE) : (pos_q - LOT_SIZE);
            id_q  <= id_q + 16'd1;
            cnt_q <= CW'(COOLDOWN_CYC - 1);
          end
        end
        COOLDOWN: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`ifdef ORDER_MGR_FLATTEN_EN
        FLATTEN: begin
          if (ord_ready) begin
            pos_q <= '0;
            id_q  <= id_q + 16'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
`ifdef ORDER_MGR_FLATTEN_EN
  assign ord_valid    = (state == ISSUE) || (state == FLATTEN);
`else
  assign ord_valid    = (state == ISSUE);
`endif
  assign halted       = (state == HALT);
  assign ord_side     = side_q;
  assign ord_qty      = qty_q;
  assign ord_id       = id_q;
  assign position_out = pos_q;

endmodule

// File: tb/tb_order_manager.sv
// Self-checking bench for order_manager: directed vector table, hand-written corner sequences
// and randomized decisions checked against a transaction-level position/order model.
module tb_order_manager;

  localparam logic [31:0] LOT = 32'h0001_0000;
  localparam int K_NONE = 0, K_BUY = 1, K_SELL = 2, K_KILL = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, allow_trade = 1'b0, kill_switch = 1'b0;
  logic        ord_ready = 1'b0, halt_clear = 1'b0;
  logic [31:0] signal_in = '0;
  logic        in_ready, ord_valid, ord_side, halted;
  logic [31:0] ord_qty, position_out;
  logic [15:0] ord_id;

  int          checks = 0, errors = 0;
  longint      pos_m;
  logic [15:0] id_m;

  typedef struct {
    logic        side;
    logic [31:0] qty;
    logic [15:0] id;
  } ord_t;
  ord_t orders[$];

  typedef struct {
    logic [31:0] sig;
    logic        allow;
    logic        kill;
    int          delay;
    int          exp_kind;
    logic [31:0] exp_pos;
  } vec_t;
  vec_t vecs[10];

  order_manager dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signal_in(signal_in), .allow_trade(allow_trade), .kill_switch(kill_switch),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side), .ord_qty(ord_qty),
    .ord_id(ord_id), .position_out(position_out), .halted(halted), .halt_clear(halt_clear)
  );

  always #5 clk = ~clk;

  // Record every completed order transfer
  always @(posedge clk) begin
    if (rst_n && ord_valid && ord_ready) orders.push_back('{ord_side, ord_qty, ord_id});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec rules in plain integer arithmetic on the current model position
  function automatic int modelKind(input logic [31:0] sig, input logic allow, input logic kill);
    longint s = longint'($signed(sig));
    if (kill) return K_KILL;
    if (!allow) return K_NONE;
    if (s >= 32768 && pos_m + 65536 <= 655360) return K_BUY;
    if (s <= -32768 && pos_m - 65536 >= -655360) return K_SELL;
    return K_NONE;
  endfunction

  task automatic doReset();
    rst_n = 1'b0; in_valid = 1'b0; ord_ready = 1'b0; halt_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pos_m = 0; id_m = '0;
    orders.delete();
    @(negedge clk);
    checkOutput("rst_valid", ord_valid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_pos", position_out, 0);
    checkOutput("rst_id", ord_id, 0);
    checkOutput("rst_ready", in_ready, 1);
  endtask

  task automatic applyStimulus(input logic [31:0] sig, input logic allow, input logic kill,
                               input int delay, input int exp_kind, input string tag);
    int n, base;
    logic has_order, is_flat, es;
    logic [31:0] eq;
    n = 0;
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    checkOutput({tag, "_ready_wait"}, in_ready, 1);
    signal_in = sig; allow_trade = allow; kill_switch = kill; in_valid = 1'b1;
    ord_ready = (delay == 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; signal_in = $urandom;
    allow_trade = 1'($urandom_range(0, 1)); kill_switch = 1'($urandom_range(0, 1));
    checkOutput({tag, "_decide_ready"}, in_ready, 0);
    checkOutput({tag, "_decide_valid"}, ord_valid, 0);
    base = orders.size();
    @(posedge clk); @(negedge clk);

    has_order = (exp_kind == K_BUY || exp_kind == K_SELL);
    is_flat = 1'b0;
    es = (exp_kind == K_BUY);
    eq = LOT;
`ifdef ORDER_MGR_FLATTEN_EN
    if (exp_kind == K_KILL && pos_m != 0) begin
      has_order = 1'b1; is_flat = 1'b1;
      es = (pos_m < 0);
      eq = (pos_m < 0) ? 32'(-pos_m) : 32'(pos_m);
    end
`endif

    if (has_order) begin
      for (int i = 0; i <= delay; i++) begin
        checkOutput({tag, "_ord_valid"}, ord_valid, 1);
        checkOutput({tag, "_ord_side"}, ord_side, es);
        checkOutput({tag, "_ord_qty"}, ord_qty, eq);
        checkOutput({tag, "_ord_id"}, ord_id, id_m);
        checkOutput({tag, "_issue_ready"}, in_ready, 0);
        if (i == delay) ord_ready = 1'b1;
        @(posedge clk); @(negedge clk);
      end
      ord_ready = 1'b0;
      checkOutput({tag, "_xfer_count"}, orders.size(), base + 1);
      if (orders.size() > base) begin
        checkOutput({tag, "_xfer_side"}, orders[base].side, es);
        checkOutput({tag, "_xfer_qty"}, orders[base].qty, eq);
        checkOutput({tag, "_xfer_id"}, orders[base].id, id_m);
      end
      if (is_flat) pos_m = 0;
      else pos_m = es ? pos_m + 65536 : pos_m - 65536;
      id_m = id_m + 16'd1;
      checkOutput({tag, "_pos"}, position_out, pos_m[31:0]);
      checkOutput({tag, "_id_next"}, ord_id, id_m);
      if (!is_flat) begin
        for (int c = 0; c < 4; c++) begin
          checkOutput({tag, "_cool_ready"}, in_ready, 0);
          halt_clear = (c == 1);
          @(negedge clk);
        end
        halt_clear = 1'b0;
        checkOutput({tag, "_cool_done"}, in_ready, 1);
      end
    end else if (exp_kind != K_KILL) begin
      checkOutput({tag, "_none_ready"}, in_ready, 1);
      checkOutput({tag, "_none_valid"}, ord_valid, 0);
      checkOutput({tag, "_none_halted"}, halted, 0);
      checkOutput({tag, "_none_pos"}, position_out, pos_m[31:0]);
      checkOutput({tag, "_none_count"}, orders.size(), base);
    end

    if (exp_kind == K_KILL) begin
      checkOutput({tag, "_halt_valid"}, ord_valid, 0);
      repeat (3) begin
        checkOutput({tag, "_halted"}, halted, 1);
        checkOutput({tag, "_halt_ready"}, in_ready, 0);
        checkOutput({tag, "_halt_pos"}, position_out, pos_m[31:0]);
        @(negedge clk);
      end
      halt_clear = 1'b1;
      @(posedge clk); @(negedge clk);
      halt_clear = 1'b0;
      checkOutput({tag, "_clr_halted"}, halted, 0);
      checkOutput({tag, "_clr_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_C000, 1'b1, 1'b0, 0, K_BUY,  32'h0001_0000};
    vecs[1] = '{32'h0000_C000, 1'b1, 1'b0, 5, K_BUY,  32'h0002_0000};
    vecs[2] = '{32'h0000_4000, 1'b1, 1'b0, 0, K_NONE, 32'h0002_0000};
    vecs[3] = '{32'h0000_C000, 1'b0, 1'b0, 0, K_NONE, 32'h0002_0000};
    vecs[4] = '{32'h0000_8000, 1'b1, 1'b0, 1, K_BUY,  32'h0003_0000};
    vecs[5] = '{32'hFFFF_8000, 1'b1, 1'b0, 0, K_SELL, 32'h0002_0000};
    vecs[6] = '{32'hFFFF_8001, 1'b1, 1'b0, 0, K_NONE, 32'h0002_0000};
    vecs[7] = '{32'h0000_7FFF, 1'b1, 1'b0, 0, K_NONE, 32'h0002_0000};
    vecs[8] = '{32'h8000_0000, 1'b1, 1'b0, 2, K_SELL, 32'h0001_0000};
    vecs[9] = '{32'h7FFF_FFFF, 1'b1, 1'b0, 0, K_BUY,  32'h0002_0000};

    doReset();
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].sig, vecs[v].allow, vecs[v].kill, vecs[v].delay,
                    vecs[v].exp_kind, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_tbl_pos", v), position_out, vecs[v].exp_pos);
    end

    // Asynchronous reset while an order is pending
    signal_in = 32'h0000_C000; allow_trade = 1'b1; kill_switch = 1'b0;
    ord_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("abort_pending", ord_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", ord_valid, 0);
    checkOutput("abort_pos", position_out, 0);
    checkOutput("abort_id", ord_id, 0);
    doReset();

    // Eleven buys against the limit
    for (int b = 0; b < 11; b++)
      applyStimulus(32'h0000_C000, 1'b1, 1'b0, 0, modelKind(32'h0000_C000, 1'b1, 1'b0),
                    $sformatf("lim%0d", b));
    checkOutput("lim_pos", position_out, 32'h000A_0000);
    checkOutput("lim_id", ord_id, 10);
    checkOutput("lim_orders", orders.size(), 10);

    // Kill after two buys, then a kill with allow low
    doReset();
    applyStimulus(32'h0000_C000, 1'b1, 1'b0, 0, K_BUY, "kb0");
    applyStimulus(32'h0000_C000, 1'b1, 1'b0, 0, K_BUY, "kb1");
    applyStimulus(32'h0000_C000, 1'b1, 1'b1, 0, K_KILL, "kill");
`ifdef ORDER_MGR_FLATTEN_EN
    checkOutput("kill_pos", position_out, 32'h0000_0000);
    checkOutput("kill_id", ord_id, 3);
    checkOutput("kill_flat_qty", (orders.size() == 3) ? orders[2].qty : 32'hDEAD_BEEF, 32'h0002_0000);
`else
    checkOutput("kill_pos", position_out, 32'h0002_0000);
    checkOutput("kill_id", ord_id, 2);
`endif
    applyStimulus(32'hFFFF_0000, 1'b0, 1'b1, 0, K_KILL, "kill2");

    // Randomized decisions against the model
    doReset();
    for (int r = 0; r < 80; r++) begin
      logic [31:0] s;
      logic a, k;
      int pick;
      pick = $urandom_range(0, 2);
      if (pick == 0) s = $urandom;
      else if (pick == 1) s = 32'($urandom_range(32'h0000_6000, 32'h0003_0000));
      else s = -32'($urandom_range(32'h0000_6000, 32'h0003_0000));
      a = ($urandom_range(0, 5) != 0);
      k = ($urandom_range(0, 19) == 0);
      applyStimulus(s, a, k, $urandom_range(0, 2), modelKind(s, a, k), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
